// File: rtl/adc_dds_source.sv
// Multi-channel DDS test source emulating one lane of ADC front-end I/Q data.
// Define ADC_DITHER_EN to add a 2-bit LFSR dither to each channel's I output.
module adc_dds_source #(
  parameter int NUM_CH      = 4,
  parameter int IQ_WIDTH    = 16,
  parameter int PHASE_WIDTH = 32,
  parameter int BURST_WIDTH = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         adc_clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [CH_W-1:0]              cfg_ch,
  input  logic [1:0]                   cfg_addr,
  input  logic [31:0]                  cfg_wdata,
  input  logic                         run,
  input  logic                         sync_in,
  input  logic [BURST_WIDTH-1:0]       burst_len,
  output logic [NUM_CH*2*IQ_WIDTH-1:0] adc_data_out,
  output logic                         adc_valid_out,
  output logic                         busy,
  output logic                         done
);

  localparam int PROD_W = IQ_WIDTH + 17;
  localparam logic signed [IQ_WIDTH-1:0] AMP = {1'b0, {(IQ_WIDTH-1){1'b1}}};
  localparam logic [PHASE_WIDTH-1:0] TUNING_RST = PHASE_WIDTH'(32'h0800_0000);

  typedef enum logic [1:0] {IDLE, RUN, BURST, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [BURST_WIDTH-1:0] cnt_reg, cnt_next;
  logic                   active;
  logic                   act1_reg, valid_reg;

  // Quarter-wave sample j of A*sin(2*pi*j/256), rounded to nearest.
  function automatic logic signed [IQ_WIDTH-1:0] lut_entry(input int j);
    real amp;
    real x;
    amp = (2.0 ** (IQ_WIDTH - 1)) - 1.0;
    x   = amp * $sin(2.0 * 3.14159265358979323846 * j / 256.0);
    return IQ_WIDTH'($rtoi(x + 0.5));
  endfunction

  // Maps the low 7 phase bits onto the 0..64 quarter table (mirrored in odd quadrants).
  function automatic logic [6:0] qw_addr(input logic [6:0] p);
    return p[6] ? (7'd64 - {1'b0, p[5:0]}) : {1'b0, p[5:0]};
  endfunction

  logic signed [IQ_WIDTH-1:0] lut [0:64];

  genvar gi;
  generate
    for (gi = 0; gi <= 64; gi++) begin : g_lut
      localparam logic signed [IQ_WIDTH-1:0] S_VAL = lut_entry(gi);
      assign lut[gi] = S_VAL;
    end
  endgenerate

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (run) begin
          if (burst_len == '0) begin
            state_next = RUN;
          end else begin
            state_next = BURST;
            cnt_next   = burst_len;
          end
        end
      end
      RUN: begin
        if (!run) state_next = IDLE;
      end
      BURST: begin
        cnt_next = cnt_reg - BURST_WIDTH'(1);
        // Dropping run aborts the burst without signalling completion.
        if (!run)                           state_next = IDLE;
        else if (cnt_reg == BURST_WIDTH'(1)) state_next = DONE;
      end
      DONE: begin
        if (!run) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign active = (state_reg == RUN) || (state_reg == BURST);
  assign busy   = active;
  assign done   = (state_reg == DONE);

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      act1_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      act1_reg  <= active;
      valid_reg <= act1_reg;
    end
  end

  assign adc_valid_out = valid_reg;

`ifdef ADC_DITHER_EN
  logic [14:0] lfsr_reg;

  // x^15 + x^14 + 1 Fibonacci LFSR, stepped only while samples are produced.
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n)      lfsr_reg <= 15'h0001;
    else if (active) lfsr_reg <= {lfsr_reg[13:0], lfsr_reg[14] ^ lfsr_reg[13]};
  end
`endif

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [PHASE_WIDTH-1:0]        acc_reg, tuning_reg, offset_reg;
      logic [15:0]                   gain_reg, gain1_reg;
      logic [1:0]                    mode_reg, mode1_reg;
      logic [7:0]                    idx1_reg, idx_q;
      logic [6:0]                    addr_i, addr_q;
      logic signed [IQ_WIDTH-1:0]    s_i, s_q, raw_i, raw_q, g_i, g_q, out_i;
      logic signed [PROD_W-1:0]      prod_i, prod_q;
      logic signed [IQ_WIDTH-1:0]    i_out_reg, q_out_reg;
      logic                          wr;

      assign wr = cfg_we && (cfg_ch == CH_W'(gi));

      always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
          tuning_reg <= TUNING_RST;
          offset_reg <= '0;
          gain_reg   <= 16'h8000;
          mode_reg   <= 2'd0;
        end else if (wr) begin
          case (cfg_addr)
            2'd0:    tuning_reg <= PHASE_WIDTH'(cfg_wdata);
            2'd1:    offset_reg <= PHASE_WIDTH'(cfg_wdata);
            2'd2:    gain_reg   <= (cfg_wdata > 32'h8000) ? 16'h8000 : cfg_wdata[15:0];
            default: mode_reg   <= cfg_wdata[1:0];
          endcase
        end
      end

      always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n)       acc_reg <= '0;
        else if (sync_in) acc_reg <= '0;
        else if (active)  acc_reg <= acc_reg + tuning_reg;
      end

      always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
          idx1_reg  <= '0;
          mode1_reg <= '0;
          gain1_reg <= '0;
        end else if (active) begin
          idx1_reg  <= 8'((acc_reg + offset_reg) >> (PHASE_WIDTH - 8));
          mode1_reg <= mode_reg;
          gain1_reg <= gain_reg;
        end
      end

      assign idx_q  = idx1_reg + 8'd64;
      assign addr_i = qw_addr(idx1_reg[6:0]);
      assign addr_q = qw_addr(idx_q[6:0]);
      assign s_i    = idx1_reg[7] ? -lut[addr_i] : lut[addr_i];
      assign s_q    = idx_q[7]    ? -lut[addr_q] : lut[addr_q];

      always_comb begin
        raw_i = '0;
        raw_q = '0;
        case (mode1_reg)
          2'd0: begin
            raw_i = s_i;
            raw_q = s_q;
          end
          2'd1: ;
          2'd2: begin
            raw_i = {idx1_reg, {(IQ_WIDTH-8){1'b0}}};
            raw_q = ~raw_i;
          end
          default: raw_i = AMP;
        endcase
      end

      // Gain is Q1.15 with 1.0 = 0x8000, so the floored product never overflows.
      assign prod_i = PROD_W'(raw_i) * PROD_W'($signed({1'b0, gain1_reg}));
      assign prod_q = PROD_W'(raw_q) * PROD_W'($signed({1'b0, gain1_reg}));
      assign g_i    = IQ_WIDTH'(prod_i >>> 15);
      assign g_q    = IQ_WIDTH'(prod_q >>> 15);

`ifdef ADC_DITHER_EN
      logic signed [1:0]        dith1_reg;
      logic signed [IQ_WIDTH:0] sum_i;

      always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n)      dith1_reg <= '0;
        else if (active) dith1_reg <= {lfsr_reg[gi % 15], lfsr_reg[(gi + 1) % 15]};
      end

      assign sum_i = (IQ_WIDTH+1)'(g_i) + (IQ_WIDTH+1)'(dith1_reg);
      always_comb begin
        out_i = sum_i[IQ_WIDTH-1:0];
        if (sum_i[IQ_WIDTH] != sum_i[IQ_WIDTH-1])
          out_i = sum_i[IQ_WIDTH] ? {1'b1, {(IQ_WIDTH-1){1'b0}}} : AMP;
      end
`else
      assign out_i = g_i;
`endif

      always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
          i_out_reg <= '0;
          q_out_reg <= '0;
        end else if (act1_reg) begin
          i_out_reg <= out_i;
          q_out_reg <= g_q;
        end
      end

      assign adc_data_out[gi*2*IQ_WIDTH +: IQ_WIDTH]            = i_out_reg;
      assign adc_data_out[gi*2*IQ_WIDTH + IQ_WIDTH +: IQ_WIDTH] = q_out_reg;
    end
  endgenerate

endmodule
